mul_share_sched: RTL
====================

Name: mul_share_sched

Overview:
- Shares one multi-cycle multiplier between NUM_REQ requesters.
- Requester arbitration is round-robin.
- Only one multiply is in flight at a time.
- The result is returned on a common response bus, tagged with the requester ID, under valid/ready backpressure.
- A completion counter exposes how many operations have finished. The bench checks it against its own expected-evaluation count.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- WIDTH, 32: operand and result width in bits.
- MUL_LAT, 2: multiplier latency in cycles (at least 1).
- ID_W, 2: width of the requester ID; must equal clog2(NUM_REQ).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester operation request.
- req_ready  out  NUM_REQ  per-requester accept strobe; at most one bit set per cycle.
- req_a  in  NUM_REQ*WIDTH  packed operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  in  NUM_REQ*WIDTH  packed operand B, same packing as req_a.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts the result.
- resp_id  out  ID_W  requester index that owns resp_data.
- resp_data  out  WIDTH  product, truncated to WIDTH bits.
- busy  out  1  high when the state is not IDLE.
- op_count  out  WIDTH  number of completed response handshakes; wraps modulo 2^WIDTH.

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous and active-low.
- Reset values:
  - state = IDLE.
  - req_ready = 0, resp_valid = 0, resp_id = 0, resp_data = 0, busy = 0, op_count = 0.
  - Round-robin pointer last_grant = NUM_REQ-1, so requester 0 has first priority.
- FSM states: IDLE, MUL, RESP.
- IDLE:
  - req_ready is combinational. It is set only for the winner, and only when at least one req_valid is high.
  - The winner is the first asserted req_valid found searching from last_grant+1 upward, wrapping modulo NUM_REQ.
  - On the accept edge:
    - latch the winner's req_a and req_b;
    - latch the winner's ID;
    - set last_grant to the winner;
    - load the latency counter with MUL_LAT;
    - go to MUL.
  - With no request, stay in IDLE; req_ready = 0.
- MUL:
  - The counter decrements each cycle.
  - When the counter reaches 1, register the product (A*B)[WIDTH-1:0] into resp_data and go to RESP.
  - The operation is unsigned; overflow bits are discarded.
- RESP:
  - resp_valid = 1. resp_id and resp_data stay stable until the handshake.
  - When resp_valid and resp_ready are both high:
    - op_count increments by 1;
    - go to IDLE;
    - resp_valid falls the next cycle.
  - If resp_ready stays low, remain in RESP indefinitely.
- Latency: an accept at edge T gives resp_valid high from edge T+MUL_LAT. With resp_ready tied high, accepts can repeat every MUL_LAT+2 cycles.
- req_ready is 0 in MUL and RESP. New requests wait and are not dropped.
- Requesters must hold req_valid and operands stable until their req_ready is seen. Changes after acceptance have no effect on the result.
- Deasserting req_valid before it is granted withdraws the request; no error is flagged.
- A requester that is valid every cycle is served at most once per NUM_REQ grants while others are also valid.
- busy = (state != IDLE), registered.
- Reset asserted mid-operation: state returns to IDLE immediately. The in-flight result is discarded, op_count clears, and last_grant resets. No response is ever produced for the aborted operation.
- Products are purely arithmetic: no X propagation from unselected requesters' operand lanes.

Test Plan:
1. Single requester 0: A=7, B=6, MUL_LAT=2, resp_ready=1 -> req_ready[0] for 1 cycle; 2 cycles later resp_valid, resp_id=0, resp_data=42; op_count=1 after the handshake.
2. All four valid at once, each with A=i+1, B=3 -> grant order 0,1,2,3,0; responses 3,6,9,12 in that order; op_count=4 after four handshakes.
3. Backpressure: resp_ready=0 for 10 cycles during RESP -> resp_valid, resp_id and resp_data stay constant; req_ready=0 throughout; exactly one handshake when resp_ready rises.
4. Overflow with WIDTH=32: A=0x8000_0001, B=2 -> resp_data=0x0000_0002.
5. Reset pulse (rst_n low 1 cycle) while in MUL for requester 2 -> no resp_valid afterwards; op_count=0; the next request from requester 0 and 2 together grants 0 first.
6. op_count wrap with WIDTH=4: 17 completed operations -> op_count=1.

Source files
------------

// File: rtl/mul_share_sched.sv
// One multi-cycle multiplier shared by NUM_REQ requesters with round-robin arbitration.
// A single operation is in flight; its truncated product returns on a tagged valid/ready bus.
module mul_share_sched #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 2,
    parameter int ID_W    = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [ID_W-1:0]          resp_id,
    output logic [WIDTH-1:0]         resp_data,
    output logic                     busy,
    output logic [WIDTH-1:0]         op_count
);

    localparam int CNT_W = (MUL_LAT < 2) ? 1 : $clog2(MUL_LAT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [ID_W-1:0]  last_q, last_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] op_q, op_d;
    logic             resp_valid_q;
    logic             busy_q;

    logic             found_s;
    logic [ID_W-1:0]  win_s;
    logic [WIDTH-1:0] prod_s;

    // Lower WIDTH bits of the unsigned product; overflow is discarded by the width.
    assign prod_s = a_q * b_q;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        int idx;
        idx     = 0;
        found_s = 1'b0;
        win_s   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_q) + k) % NUM_REQ;
            if (!found_s && req_valid[idx]) begin
                found_s = 1'b1;
                win_s   = ID_W'(idx);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state and datapath update for the IDLE/MUL/RESP sequencer.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        id_d      = id_q;
        last_d    = last_q;
        data_d    = data_q;
        op_d      = op_q;
        req_ready = '0;
        case (state_q)
            IDLE: begin
                if (found_s) begin
                    req_ready[win_s] = 1'b1;
                    a_d              = req_a[int'(win_s)*WIDTH +: WIDTH];
                    b_d              = req_b[int'(win_s)*WIDTH +: WIDTH];
                    id_d             = win_s;
                    last_d           = win_s;
                    cnt_d            = CNT_W'(MUL_LAT);
                    state_d          = MUL;
                end else begin
                    state_d = IDLE;
                end
            end
            MUL: begin
                if (cnt_q == CNT_W'(1)) begin
                    data_d  = prod_s;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (resp_ready) begin
                    op_d    = op_q + WIDTH'(1);
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; status outputs are registered from next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= '0;
            last_q       <= ID_W'(NUM_REQ - 1);
            data_q       <= '0;
            op_q         <= '0;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            a_q          <= a_d;
            b_q          <= b_d;
            id_q         <= id_d;
            last_q       <= last_d;
            data_q       <= data_d;
            op_q         <= op_d;
            resp_valid_q <= (state_d == RESP);
            busy_q       <= (state_d != IDLE);
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_id    = id_q;
    assign resp_data  = data_q;
    assign busy       = busy_q;
    assign op_count   = op_q;

endmodule
